// File: rtl/typedefs.sv
// typedefs: shared types and defaults for the memory subsystem
package typedefs;
  localparam int DEFAULT_WORD_W = 8;
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} bist_state_e;
endpackage

// File: rtl/mem_bist_cmp.sv
// mem_bist_cmp: read-compare pipeline stage and mismatch accumulator for mem_bist
module mem_bist_cmp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  cmp_vld,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] want,
  output logic [ADDR_WIDTH-1:0] cmp_addr,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [ADDR_WIDTH+1:0] fail_cnt
);
  logic vld_q;
  logic miss;
  assign miss = vld_q && rdata != want;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= 1'b0;
      cmp_addr  <= '0;
      fail_addr <= '0;
      fail_cnt  <= '0;
    end else if (clear) begin
      vld_q     <= 1'b0;
      cmp_addr  <= '0;
      fail_addr <= '0;
      fail_cnt  <= '0;
    end else begin
      vld_q    <= cmp_vld;
      cmp_addr <= addr;
      if (miss) begin
        fail_cnt <= fail_cnt + (ADDR_WIDTH+2)'(1);
        // a zero count means this is the first mismatch of the run
        if (fail_cnt == '0) fail_addr <= cmp_addr;
      end
    end
  end
endmodule

// File: rtl/mem_bist.sv
// mem_bist: two-pass write/read-back self-test initiator for a single-port synchronous memory
module mem_bist
  import typedefs::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = DEFAULT_WORD_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [ADDR_WIDTH+1:0] fail_cnt
);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  bist_state_e           state;
  logic [ADDR_WIDTH-1:0] addr, nxt, cmp_addr;
  logic [DATA_WIDTH-1:0] seed_q, want;
  logic                  p, start_ok;
  function automatic logic [DATA_WIDTH-1:0] pattern(logic [ADDR_WIDTH-1:0] a, logic inv);
    return seed_q ^ DATA_WIDTH'(a) ^ {DATA_WIDTH{inv}};
  endfunction
  assign nxt      = addr + ADDR_WIDTH'(1);
  assign start_ok = start && (state == IDLE || state == DONE);
  assign want     = pattern(cmp_addr, p);
  assign pass     = done && fail_cnt == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      p         <= 1'b0;
      seed_q    <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (start_ok) begin
      state     <= WRITE;
      seed_q    <= seed;
      p         <= 1'b0;
      addr      <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= seed;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      case (state)
        WRITE: begin
          addr      <= nxt;
          mem_addr  <= {1'b0, nxt};
          mem_wdata <= pattern(nxt, p);
          if (addr == LAST) begin
            state     <= READ;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
          end
        end
        READ: begin
          addr     <= nxt;
          mem_addr <= {1'b0, nxt};
          if (addr == LAST) begin
            state    <= DRAIN;
            mem_read <= 1'b0;
          end
        end
        DRAIN: begin
          // addr has already wrapped to 0, ready for the inverted pass
          if (!p) begin
            p         <= 1'b1;
            state     <= WRITE;
            mem_write <= 1'b1;
            mem_wdata <= pattern(ADDR_WIDTH'(0), 1'b1);
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  mem_bist_cmp #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) cmp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .cmp_vld  (mem_read),
    .addr     (mem_addr[ADDR_WIDTH-1:0]),
    .rdata    (mem_rdata),
    .want     (want),
    .cmp_addr (cmp_addr),
    .fail_addr(fail_addr),
    .fail_cnt (fail_cnt)
  );
endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: directed self-checking bench for mem_bist with a fault-injecting memory model
module tb_mem_bist;
  localparam int AW = 5, DW = 8, DEPTH = 32;
  logic clk = 0, rst_n = 0, start = 0;
  logic [DW-1:0] seed = 0;
  logic mem_read, mem_write, busy, done, pass;
  logic [AW:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [AW-1:0] fail_addr;
  logic [AW+1:0] fail_cnt;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] f_or [DEPTH];
  logic [DW-1:0] f_xor [DEPTH];
  int checks = 0, passed = 0, both = 0, msb = 0;
  always #5 clk = ~clk;
  mem_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .pass(pass), .fail_addr(fail_addr), .fail_cnt(fail_cnt)
  );
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[AW-1:0]] <= mem_wdata;
    if (mem_read) mem_rdata <= (mem[mem_addr[AW-1:0]] | f_or[mem_addr[AW-1:0]]) ^ f_xor[mem_addr[AW-1:0]];
  end
  always @(negedge clk) begin
    if (mem_read && mem_write) both++;
    if (mem_addr[AW]) msb++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask
  function automatic logic [31:0] outs();
    return 32'({mem_read, mem_write, mem_addr, mem_wdata, busy, done, pass, fail_addr, fail_cnt});
  endfunction
  task automatic clear_faults();
    foreach (f_or[i]) begin
      f_or[i] = '0;
      f_xor[i] = '0;
    end
  endtask
  task automatic run(input logic [DW-1:0] s, input bit ign, output int bc, output logic [31:0] fw);
    int t = 0;
    bc = 0;
    fw = '0;
    @(negedge clk);
    seed = s;
    start = 1;
    @(negedge clk);
    start = 0;
    while (!done && t < 400) begin
      if (t == 0) fw = 32'({mem_write, mem_addr, mem_wdata});
      bc += int'(busy);
      start = ign && (bc == 10 || bc == 70);
      @(negedge clk);
      t++;
    end
    start = 0;
    check("done_timeout", 32'(t < 400), 1);
  endtask
  initial begin
    int bc, mm;
    logic [31:0] fw;
    clear_faults();
    rst_n = 0;
    start = 1;
    seed = 8'h33;
    repeat (3) @(negedge clk);
    check("rst_outs", outs(), 0);
    rst_n = 1;
    start = 0;
    repeat (3) @(negedge clk);
    check("rst_idle", outs(), 0);
    run(8'hA5, 0, bc, fw);
    check("first_wr", fw, {17'd0, 1'b1, 6'd0, 8'hA5});
    check("clean_busy", bc, 130);
    check("clean_done", done, 1);
    check("clean_pass", pass, 1);
    check("clean_cnt", fail_cnt, 0);
    mm = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== (8'h5A ^ 8'(a))) mm++;
    check("clean_mem", mm, 0);
    check("mem5", mem[5], 8'h5F);
    f_or[5] = 8'h01;
    run(8'hA5, 0, bc, fw);
    check("stuck_pass", pass, 0);
    check("stuck_cnt", fail_cnt, 1);
    check("stuck_addr", fail_addr, 5);
    clear_faults();
    f_xor[3] = 8'h01;
    f_xor[20] = 8'h01;
    run(8'hA5, 0, bc, fw);
    check("dual_cnt", fail_cnt, 4);
    check("dual_addr", fail_addr, 3);
    check("dual_pass", pass, 0);
    clear_faults();
    @(negedge clk);
    seed = 8'hA5;
    start = 1;
    @(negedge clk);
    start = 0;
    check("restart_done", done, 0);
    check("restart_cnt", fail_cnt, 0);
    check("restart_addr", fail_addr, 0);
    check("restart_busy", busy, 1);
    repeat (135) @(negedge clk);
    check("restart_fin", {done, pass}, 2'b11);
    run(8'h3C, 1, bc, fw);
    check("ign_busy", bc, 130);
    check("ign_pass", pass, 1);
    @(negedge clk);
    seed = 8'hC3;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (79) @(negedge clk);
    check("mid_wr", {busy, mem_write}, 2'b11);
    #2 rst_n = 0;
    #1 check("mid_rst_outs", outs(), 0);
    @(negedge clk);
    rst_n = 1;
    run(8'h00, 0, bc, fw);
    check("fresh_busy", bc, 130);
    check("fresh_pass", pass, 1);
    check("fresh_cnt", fail_cnt, 0);
    check("strobes_both", both, 0);
    check("addr_msb", msb, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_bist.md
# mem_bist

Built-in self-test engine that acts as the initiator on the single-port synchronous memory interface: `read`/`write` strobes, `addr`, `data_in`, and registered `data_out`. On `start` it runs two passes over every address. Each pass writes a seed-derived pattern to all addresses, then reads every address back and compares the result against the expected value. It reports pass/fail, the first failing address, and a mismatch count. It sits beside `memory_module` and drives that block's ports directly; normal traffic is muxed in above this block.

## Interface
- `ADDR_WIDTH`, default 5: memory depth is DEPTH = 2**ADDR_WIDTH words.
- `DATA_WIDTH`, default `DEFAULT_WORD_W`: word width. Must equal the memory word width.
- `clk`  in  1: single clock. All logic is rising-edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: one-cycle run request. Accepted only in IDLE or DONE.
- `seed`  in  DATA_WIDTH: pattern seed, sampled when `start` is accepted.
- `mem_read`  out  1: read strobe to memory.
- `mem_write`  out  1: write strobe to memory.
- `mem_addr`  out  ADDR_WIDTH+1: memory address. The MSB is always 0.
- `mem_wdata`  out  DATA_WIDTH: write data.
- `mem_rdata`  in  DATA_WIDTH: memory registered read data.
- `busy`  out  1: run in progress.
- `done`  out  1: run finished. Held until the next accepted `start`.
- `pass`  out  1: valid while `done`. High when `fail_cnt` == 0.
- `fail_addr`  out  ADDR_WIDTH: address of the first mismatch in the run.
- `fail_cnt`  out  ADDR_WIDTH+2: total mismatches across both passes, at most 2*DEPTH.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE. A 1-bit pass index `p` selects the pattern.
- Pattern: E(a) = `seed_q` ^ a, with a zero-extended or truncated to DATA_WIDTH.
  - Pass 0 uses E(a).
  - Pass 1 uses ~E(a).
- IDLE/DONE + `start`: latch `seed_q`; set `p`=0 and `addr`=0; clear `fail_cnt`, `fail_addr` and `done`; go to WRITE.
- WRITE: drive `mem_write`=1 and `mem_wdata` = pattern(`addr`), then increment `addr`. At `addr` = DEPTH-1, wrap to 0 and go to READ.
- READ: drive `mem_read`=1 at `addr`. Register `addr` into `cmp_addr` and set `cmp_vld`=1. At `addr` = DEPTH-1, go to DRAIN.
- Compare: on the cycle after each read, if `cmp_vld` and `mem_rdata` != pattern(`cmp_addr`):
  - increment `fail_cnt`;
  - if this is the first mismatch of the run, capture `fail_addr` = `cmp_addr`.
- DRAIN: no strobes; the final compare happens here. Then:
  - if `p`=0, set `p`=1 and `addr`=0, and go to WRITE;
  - otherwise go to DONE.
- DONE: `done`=1 and `busy`=0. Results are held.
- `mem_read` and `mem_write` are never high in the same cycle. Both are 0 outside WRITE/READ.
- `start` while `busy` is ignored.

## Timing
- Reset values: state IDLE; `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, `busy`, `done`, `pass`, `fail_addr`, `fail_cnt` are all 0.
- Reset applies immediately and asynchronously, including mid-run. No partial results survive reset.
- Strobes, `mem_addr` and `mem_wdata` are registered outputs.
- The first write strobe appears in the cycle after `start` is sampled.
- Read latency is 1 cycle: `mem_rdata` for the strobe at cycle t is compared at t+1.
- Per pass: DEPTH write cycles + DEPTH read cycles + 1 DRAIN cycle.
- A full run is 2*(2*DEPTH+1) busy cycles; `done` rises on the next cycle. With ADDR_WIDTH=5 this is 130 cycles.
- `busy` rises in the cycle after `start` and falls together with the rise of `done`.
- `pass` updates with `done`.
- Counter arithmetic is unsigned. `fail_cnt` cannot overflow because its width covers 2*DEPTH.

## Structure
- `bist_state_e`, an enum of the five states, goes in the shared `typedefs` package. `DEFAULT_WORD_W` also comes from that package.
- One sub-module: `mem_bist_cmp`. It holds the compare pipeline register plus the `fail_cnt`/`fail_addr` accumulator, and has `clear` and `cmp_vld` inputs.
- The FSM, address counter and pattern generator stay in `mem_bist`.

## Test plan
- Reset: assert `rst_n`=0 at random points -> every output is 0 and the state is IDLE. `start` during reset has no effect.
- Clean memory, ADDR_WIDTH=5, DATA_WIDTH=8, seed=8'hA5 -> writes of 8'hA5^a then 8'h5A^a. After 130 busy cycles: `done`=1, `pass`=1, `fail_cnt`=0. Strobes are never both high.
- Memory model with bit 0 stuck at 1 at address 5 only -> `pass`=0, `fail_cnt`=1, `fail_addr`=5. Pass 0 expects 8'hA0 (mismatch); pass 1 expects 8'h5F (match).
- Faults at addresses 3 and 20 on both passes -> `fail_cnt`=4, `fail_addr`=3.
- `start` pulsed at cycles 10 and 70 of a run -> both ignored; the run still ends at 130 cycles.
- `rst_n` pulsed low during pass 1 WRITE, then `start` with seed=8'h00 -> a full fresh 130-cycle run with `pass`=1. Re-`start` from DONE clears `done` and all results in the next cycle.
